// File: rtl/window_stat_filter.sv
// Sliding-window statistics kernel: per-pixel rounded mean, max, min or centre
// bypass over a P x P window, with a fixed 4-cycle latency and matching sync delay.
module window_stat_filter #(
    parameter int unsigned P_DATA_WIDTH   = 8,
    parameter int unsigned P_SLIDE_WINDOW = 3
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst_n,
    input  logic                                                  i_h_sync,
    input  logic                                                  i_v_sync,
    input  logic [1:0]                                            i_mode,
    input  logic [P_DATA_WIDTH*P_SLIDE_WINDOW*P_SLIDE_WINDOW-1:0] i_data,
    output logic                                                  o_h_sync,
    output logic                                                  o_v_sync,
    output logic [P_DATA_WIDTH-1:0]                               o_data,
    output logic [1:0]                                            o_mode
);

    localparam int unsigned W      = P_DATA_WIDTH;
    localparam int unsigned P      = P_SLIDE_WINDOW;
    localparam int unsigned N      = P * P;
    localparam int unsigned ROW_W  = W + $clog2(P);
    localparam int unsigned SUM_W  = W + $clog2(N);
    localparam int unsigned CENTER = (N - 1) / 2;

    localparam logic [1:0] MODE_MEAN = 2'd0;
    localparam logic [1:0] MODE_MAX  = 2'd1;
    localparam logic [1:0] MODE_MIN  = 2'd2;

    // Stage 1 state
    logic           v_prev;
    logic [1:0]     mode_next;
    logic           s1_valid;
    logic           s1_h;
    logic           s1_v;
    logic [1:0]     s1_mode;
    logic [N*W-1:0] s1_data;

    // Stage 2 state
    logic [ROW_W-1:0] row_sum_c [P];
    logic [W-1:0]     row_max_c [P];
    logic [W-1:0]     row_min_c [P];
    logic [W-1:0]     px_c;
    logic [ROW_W-1:0] s2_sum [P];
    logic [W-1:0]     s2_max [P];
    logic [W-1:0]     s2_min [P];
    logic [W-1:0]     s2_center;
    logic             s2_valid;
    logic             s2_h;
    logic             s2_v;
    logic [1:0]       s2_mode;

    // Stage 3 state
    logic [SUM_W-1:0] tot_sum_c;
    logic [W-1:0]     tot_max_c;
    logic [W-1:0]     tot_min_c;
    logic [SUM_W-1:0] s3_sum;
    logic [W-1:0]     s3_max;
    logic [W-1:0]     s3_min;
    logic [W-1:0]     s3_center;
    logic             s3_valid;
    logic             s3_h;
    logic             s3_v;
    logic [1:0]       s3_mode;

    // Stage 4 combinational
    logic [SUM_W-1:0] mean_c;
    logic [W-1:0]     stat_c;

    // New mode takes effect on the first pixel of a frame (v_sync rising edge).
    always_comb begin
        mode_next = o_mode;
        if (i_v_sync && !v_prev) begin
            mode_next = i_mode;
        end
    end

    // v_prev resets high so a frame already in flight at reset release is not seen as a new frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_prev   <= 1'b1;
            o_mode   <= '0;
            s1_valid <= 1'b0;
            s1_h     <= 1'b0;
            s1_v     <= 1'b0;
            s1_mode  <= '0;
            s1_data  <= '0;
        end else begin
            v_prev   <= i_v_sync;
            o_mode   <= mode_next;
            s1_valid <= i_h_sync && i_v_sync;
            s1_h     <= i_h_sync;
            s1_v     <= i_v_sync;
            s1_mode  <= mode_next;
            s1_data  <= i_data;
        end
    end

    // Per-row sum, max and min.
    always_comb begin
        px_c = '0;
        for (int r = 0; r < int'(P); r++) begin
            row_sum_c[r] = '0;
            row_max_c[r] = '0;
            row_min_c[r] = '1;
            for (int c = 0; c < int'(P); c++) begin
                px_c         = s1_data[(r*int'(P)+c)*int'(W) +: W];
                row_sum_c[r] = row_sum_c[r] + ROW_W'(px_c);
                if (px_c > row_max_c[r]) row_max_c[r] = px_c;
                if (px_c < row_min_c[r]) row_min_c[r] = px_c;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < int'(P); r++) begin
                s2_sum[r] <= '0;
                s2_max[r] <= '0;
                s2_min[r] <= '0;
            end
            s2_center <= '0;
            s2_valid  <= 1'b0;
            s2_h      <= 1'b0;
            s2_v      <= 1'b0;
            s2_mode   <= '0;
        end else begin
            for (int r = 0; r < int'(P); r++) begin
                s2_sum[r] <= row_sum_c[r];
                s2_max[r] <= row_max_c[r];
                s2_min[r] <= row_min_c[r];
            end
            s2_center <= s1_data[CENTER*W +: W];
            s2_valid  <= s1_valid;
            s2_h      <= s1_h;
            s2_v      <= s1_v;
            s2_mode   <= s1_mode;
        end
    end

    // Cross-row reduction.
    always_comb begin
        tot_sum_c = '0;
        tot_max_c = '0;
        tot_min_c = '1;
        for (int r = 0; r < int'(P); r++) begin
            tot_sum_c = tot_sum_c + SUM_W'(s2_sum[r]);
            if (s2_max[r] > tot_max_c) tot_max_c = s2_max[r];
            if (s2_min[r] < tot_min_c) tot_min_c = s2_min[r];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s3_sum    <= '0;
            s3_max    <= '0;
            s3_min    <= '0;
            s3_center <= '0;
            s3_valid  <= 1'b0;
            s3_h      <= 1'b0;
            s3_v      <= 1'b0;
            s3_mode   <= '0;
        end else begin
            s3_sum    <= tot_sum_c;
            s3_max    <= tot_max_c;
            s3_min    <= tot_min_c;
            s3_center <= s2_center;
            s3_valid  <= s2_valid;
            s3_h      <= s2_h;
            s3_v      <= s2_v;
            s3_mode   <= s2_mode;
        end
    end

    // Rounded mean cannot exceed the pixel range, so the narrowing is lossless.
    always_comb begin
        mean_c = (s3_sum + SUM_W'(N / 2)) / SUM_W'(N);
        case (s3_mode)
            MODE_MEAN: stat_c = W'(mean_c);
            MODE_MAX:  stat_c = s3_max;
            MODE_MIN:  stat_c = s3_min;
            default:   stat_c = s3_center;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data   <= '0;
            o_h_sync <= 1'b0;
            o_v_sync <= 1'b0;
        end else begin
            o_data   <= s3_valid ? stat_c : '0;
            o_h_sync <= s3_h;
            o_v_sync <= s3_v;
        end
    end

endmodule

// File: tb/tb_window_stat_filter.sv
// Bench for window_stat_filter: P=3/W=8 and P=5/W=12 instances driven in lockstep,
// checked every cycle against a frame-level reference model.
module tb_window_stat_filter;

    localparam int W3 = 8;
    localparam int N3 = 9;
    localparam int W5 = 12;
    localparam int N5 = 25;

    typedef struct {
        int data;
        bit h;
        bit v;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              h;
    logic              v;
    logic [1:0]        mode;
    logic [W3*N3-1:0]  d3;
    logic [W5*N5-1:0]  d5;
    logic              oh3, ov3, oh5, ov5;
    logic [W3-1:0]     od3;
    logic [W5-1:0]     od5;
    logic [1:0]        om3, om5;

    int   checks = 0;
    int   errors = 0;
    int   win3 [N3];
    int   win5 [N5];
    int   m_mode;
    bit   m_prev_v;
    exp_t hist3 [4];
    exp_t hist5 [4];

    window_stat_filter #(.P_DATA_WIDTH(W3), .P_SLIDE_WINDOW(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_h_sync(h), .i_v_sync(v), .i_mode(mode),
        .i_data(d3), .o_h_sync(oh3), .o_v_sync(ov3), .o_data(od3), .o_mode(om3)
    );

    window_stat_filter #(.P_DATA_WIDTH(W5), .P_SLIDE_WINDOW(5)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_h_sync(h), .i_v_sync(v), .i_mode(mode),
        .i_data(d5), .o_h_sync(oh5), .o_v_sync(ov5), .o_data(od5), .o_mode(om5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Statistic over a flat window given in row-major order.
    function automatic int ref_stat(input int q[$], input int md);
        int n = q.size();
        int s = 0;
        int mx = q[0];
        int mn = q[0];
        foreach (q[i]) begin
            s += q[i];
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
        end
        case (md)
            0:       return (s + n / 2) / n;
            1:       return mx;
            2:       return mn;
            default: return q[(n - 1) / 2];
        endcase
    endfunction

    function automatic exp_t make_exp3();
        exp_t e;
        int q[$];
        foreach (win3[i]) q.push_back(win3[i]);
        e.h = h;
        e.v = v;
        e.data = (h && v) ? ref_stat(q, m_mode) : 0;
        return e;
    endfunction

    function automatic exp_t make_exp5();
        exp_t e;
        int q[$];
        foreach (win5[i]) q.push_back(win5[i]);
        e.h = h;
        e.v = v;
        e.data = (h && v) ? ref_stat(q, m_mode) : 0;
        return e;
    endfunction

    task automatic set3(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        win3[0] = a0; win3[1] = a1; win3[2] = a2;
        win3[3] = a3; win3[4] = a4; win3[5] = a5;
        win3[6] = a6; win3[7] = a7; win3[8] = a8;
    endtask

    task automatic rand3();
        foreach (win3[i]) win3[i] = int'($urandom_range(0, 255));
    endtask

    task automatic clear_model();
        m_mode   = 0;
        m_prev_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hist3[i] = '{0, 1'b0, 1'b0};
            hist5[i] = '{0, 1'b0, 1'b0};
        end
    endtask

    // One clock: drive current window, advance the model, compare outputs after the edge.
    task automatic cycle();
        foreach (win5[i]) win5[i] = int'($urandom_range(0, 4095));
        foreach (win3[i]) d3[i*W3 +: W3] = W3'(win3[i]);
        foreach (win5[i]) d5[i*W5 +: W5] = W5'(win5[i]);
        @(posedge clk);
        if (v && !m_prev_v) m_mode = int'(mode);
        m_prev_v = v;
        for (int i = 3; i > 0; i--) begin
            hist3[i] = hist3[i-1];
            hist5[i] = hist5[i-1];
        end
        hist3[0] = make_exp3();
        hist5[0] = make_exp5();
        #1;
        check("p3_data", 32'(od3), 32'(hist3[3].data));
        check("p3_hsync", 32'(oh3), 32'(hist3[3].h));
        check("p3_vsync", 32'(ov3), 32'(hist3[3].v));
        check("p3_mode", 32'(om3), 32'(m_mode));
        check("p5_data", 32'(od5), 32'(hist5[3].data));
        check("p5_hsync", 32'(oh5), 32'(hist5[3].h));
        check("p5_vsync", 32'(ov5), 32'(hist5[3].v));
        check("p5_mode", 32'(om5), 32'(m_mode));
        @(negedge clk);
    endtask

    task automatic hold(input int n);
        repeat (n) cycle();
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_p3_data", 32'(od3), 32'd0);
        check("rst_p3_sync", 32'({oh3, ov3}), 32'd0);
        check("rst_p3_mode", 32'(om3), 32'd0);
        check("rst_p5_data", 32'(od5), 32'd0);
        check("rst_p5_sync", 32'({oh5, ov5}), 32'd0);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        h = 1'b0;
        v = 1'b0;
        mode = 2'd0;
        d3 = '0;
        d5 = '0;
        set3(0, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (win5[i]) win5[i] = 0;
        clear_model();
        #1;
        check("init_p3_data", 32'(od3), 32'd0);
        check("init_p3_mode", 32'(om3), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hold(3);

        // Mean mode, constant window of 10.
        h = 1'b1; v = 1'b1; mode = 2'd0;
        set3(10, 10, 10, 10, 10, 10, 10, 10, 10);
        hold(4);
        check("mean_const10", 32'(od3), 32'd10);
        check("mean_const10_h", 32'(oh3), 32'd1);

        set3(0, 1, 2, 3, 4, 5, 6, 7, 8);
        hold(4);
        check("mean_sum36", 32'(od3), 32'd4);
        set3(0, 1, 2, 3, 4, 5, 6, 7, 12);
        hold(4);
        check("mean_sum40", 32'(od3), 32'd4);
        set3(0, 1, 2, 3, 4, 5, 6, 7, 13);
        hold(4);
        check("mean_sum41", 32'(od3), 32'd5);
        set3(255, 255, 255, 255, 255, 255, 255, 255, 255);
        hold(4);
        check("mean_all255", 32'(od3), 32'd255);

        // Mid-frame mode change is ignored.
        mode = 2'd1;
        set3(7, 200, 3, 9, 0, 255, 12, 1, 5);
        hold(4);
        check("midframe_mean", 32'(od3), 32'd55);
        check("midframe_mode", 32'(om3), 32'd0);

        // One-cycle v_sync gap re-latches the mode.
        v = 1'b0;
        hold(1);
        v = 1'b1;
        hold(1);
        check("latch_mode_max", 32'(om3), 32'd1);
        hold(3);
        check("window_max", 32'(od3), 32'd255);

        mode = 2'd2;
        v = 1'b0; hold(1); v = 1'b1;
        hold(4);
        check("window_min", 32'(od3), 32'd0);

        mode = 2'd3;
        v = 1'b0; hold(1); v = 1'b1;
        hold(4);
        check("window_centre", 32'(od3), 32'd0);

        // Gating: h_sync toggles every cycle.
        for (int i = 0; i < 40; i++) begin
            h = i[0];
            if (i % 10 == 9) begin
                v = 1'b0;
                mode = 2'($urandom_range(0, 3));
            end else begin
                v = 1'b1;
            end
            rand3();
            cycle();
        end

        // Random regression across all modes.
        for (int i = 0; i < 200; i++) begin
            h = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 15) != 0);
            mode = 2'($urandom_range(0, 3));
            rand3();
            cycle();
        end

        // Reset with the pipeline full and v_sync high.
        h = 1'b1; v = 1'b1; mode = 2'd2;
        v = 1'b0; hold(1); v = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand3();
            cycle();
        end
        do_reset();
        mode = 2'd1;
        for (int i = 0; i < 8; i++) begin
            rand3();
            cycle();
        end
        check("post_reset_mode", 32'(om3), 32'd0);
        v = 1'b0; hold(1); v = 1'b1;
        for (int i = 0; i < 30; i++) begin
            h = ($urandom_range(0, 3) != 0);
            rand3();
            cycle();
        end
        check("post_reset_relatch", 32'(om3), 32'd1);

        h = 1'b0; v = 1'b0;
        hold(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
